uart_mem_bridge: RTL
====================

Name: uart_mem_bridge

Overview:
- FPGA-side initiator that turns PicoRV32 native memory transactions into request frames on a UART, then waits for the host's response frame.
- The host-side responder serves memory; the bridge completes the CPU handshake when the response arrives.
- Sits between the core and the rx_i/tx_o pins of the icesugar top.
- Contains its own 8N1 transmitter and receiver, a framing FSM and a response timeout.

Parameters:
- ClkFreq, 12000000, core clock in Hz.
- BaudRate, 115200, UART bit rate. BitCycles = ClkFreq/BaudRate, integer division (104 at defaults).
- TimeoutCycles, 2000000, idle cycles allowed between the last TX stop bit or last RX byte and the next RX byte.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous active-low reset
- mem_valid_i  in  1  CPU request valid
- mem_instr_i  in  1  instruction fetch flag; sets opcode bit 7
- mem_addr_i  in  32  byte address
- mem_wdata_i  in  32  write data
- mem_wstrb_i  in  4  byte strobes; 0 means read
- mem_ready_o  out  1  one-cycle completion pulse
- mem_rdata_o  out  32  read data, valid when mem_ready_o=1
- rx_i  in  1  UART from host, asynchronous
- tx_o  out  1  UART to host
- busy_o  out  1  transaction in progress
- err_o  out  1  sticky error flag

Behaviour:
- Clock/reset: one clock domain, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset values: tx_o=1, mem_ready_o=0, mem_rdata_o=0, busy_o=0, err_o=0, FSM in IDLE, all counters 0.
- Reset mid-frame: the frame is abandoned and tx_o returns high on the next edge.
- UART TX: 8N1, LSB first, each bit held BitCycles cycles. Bytes are back-to-back, 10*BitCycles per byte, no gap.
- UART RX: rx_i goes through a 2-flop synchronizer.
  - A falling edge starts a frame. The start bit is re-checked low at BitCycles/2; if high, the frame is dropped as a glitch.
  - Data bits are sampled at bit centres.
  - Stop bit low: the byte is discarded and err_o is set.
  - RX bytes arriving in IDLE or TX states are discarded.
- Request frame:
  - Opcode byte: 0x52 for read, 0x57 for write, OR 0x80 if mem_instr_i.
  - Address, 4 bytes, little-endian.
  - Writes only: wstrb byte {4'b0, wstrb}, then wdata, 4 bytes little-endian.
- Response frame:
  - Read: 4 data bytes, little-endian.
  - Write: 1 ack byte; expected value 0x06.
- FSM: IDLE -> TX_OP -> TX_ADDR(4) -> [TX_STRB -> TX_DATA(4) when write] -> RX_RESP -> DONE -> IDLE.
- Accept: in IDLE with mem_valid_i=1, addr/wdata/wstrb/instr are latched, busy_o=1, and TX of the opcode starts on the next cycle. Later changes to the inputs are ignored.
- RX_RESP:
  - A byte counter collects 4 bytes (read) or 1 byte (write).
  - The timeout counter restarts after each received byte and at the end of the last TX stop bit.
- DONE: lasts one cycle.
  - mem_ready_o=1 and mem_rdata_o is updated (reads only).
  - busy_o drops on the following cycle.
  - mem_rdata_o holds its value until the next read completes.
  - Writes leave mem_rdata_o unchanged.
- New-request timing: a request cannot be accepted in the DONE cycle. The earliest accept is the cycle after DONE, if mem_valid_i is still high.
- Latency:
  - Read: 9 bytes, about 90*BitCycles cycles plus host turnaround.
  - Write: 11 bytes.
- Boundary conditions:
  - Ack byte not equal to 0x06: err_o=1, transaction still completes.
  - Timeout in RX_RESP: err_o=1 and DONE is entered. Reads return mem_rdata_o=32'hFFFF_FFFF.
  - Bytes received after a timeout are dropped.
  - err_o clears only on reset.
  - A received byte that completes on the same cycle the timeout expires counts as received; the timeout is ignored.
  - A mem_valid_i deassert mid-transaction is illegal for the core. The bridge still finishes the frame.

Test Plan:
- Read of 0x0000_0010, host returns 0xEF,0xBE,0xAD,0xDE -> TX bytes 52 10 00 00 00; one mem_ready_o pulse with mem_rdata_o=0xDEADBEEF; err_o=0.
- Instruction fetch of 0x0000_0000 -> opcode 0xD2 observed on tx_o; tx_o bit width exactly 104 cycles at defaults.
- Write 0x1234_5678 to 0x0000_0100 with wstrb 0x3, host acks 0x06 -> TX 57 00 01 00 00 03 78 56 34 12; mem_ready_o pulse; mem_rdata_o unchanged.
- Write acked with 0x15 -> mem_ready_o pulse and err_o=1 sticky; err_o still 1 after a following successful read.
- Read with host silent (TimeoutCycles=5000) -> mem_ready_o pulses about 5000 cycles after the last stop bit; mem_rdata_o=0xFFFFFFFF; err_o=1.
- rst_ni low during TX_ADDR, plus a 20-cycle low glitch on rx_i while idle -> tx_o=1 the cycle after reset; no byte decoded from the glitch; busy_o=0; next read completes normally.

Source files
------------

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: PicoRV32 native memory bus to UART request/response bridge with 8N1 TX/RX and response timeout
module uart_mem_bridge #(
  parameter int ClkFreq       = 12000000,
  parameter int BaudRate      = 115200,
  parameter int TimeoutCycles = 2000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_valid_i,
  input  logic        mem_instr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        err_o
);
  localparam int BitCycles = ClkFreq / BaudRate;
  localparam int CW = $clog2(BitCycles);
  localparam int TW = $clog2(TimeoutCycles);
  typedef enum logic [1:0] {IDLE, TX, RX_RESP, DONE} state_t;
  state_t state;
  logic rx_s1, rx_s2, rx_q, rx_busy, rx_vld, rx_ferr, wr;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [3:0] rx_bit, tx_bit, tx_left;
  logic [7:0] rx_sh;
  logic [8:0] tx_sh;
  logic [79:0] frm;
  logic [2:0] rx_num;
  logic [31:0] rsh;
  logic [TW-1:0] tmo;
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      {rx_s1, rx_s2, rx_q} <= '1;
      rx_busy <= 1'b0;
      rx_vld <= 1'b0;
      rx_ferr <= 1'b0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_q <= rx_s2;
      rx_vld <= 1'b0;
      rx_ferr <= 1'b0;
      if (!rx_busy) begin
        if (rx_q && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_bit <= '0;
          rx_cnt <= CW'(BitCycles / 2 - 1);
        end
      end else if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
      else begin
        rx_cnt <= CW'(BitCycles - 1);
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == 4'd0 && rx_s2) rx_busy <= 1'b0;
        else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          rx_vld <= rx_s2;
          rx_ferr <= !rx_s2;
        end else if (rx_bit != 4'd0) rx_sh <= {rx_s2, rx_sh[7:1]};
      end
    end
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state <= IDLE;
      tx_o <= 1'b1;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      busy_o <= 1'b0;
      err_o <= 1'b0;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_left <= '0;
      tx_sh <= '0;
      frm <= '0;
      wr <= 1'b0;
      rx_num <= '0;
      rsh <= '0;
      tmo <= '0;
    end else begin
      mem_ready_o <= 1'b0;
      if (rx_ferr) err_o <= 1'b1;
      case (state)
        IDLE: if (mem_valid_i) begin
          state <= TX;
          busy_o <= 1'b1;
          wr <= |mem_wstrb_i;
          frm <= {mem_wdata_i, 4'b0, mem_wstrb_i, mem_addr_i, mem_instr_i, 1'b1, (|mem_wstrb_i) ? 6'h17 : 6'h12};
          tx_left <= (|mem_wstrb_i) ? 4'd10 : 4'd5;
          rx_num <= (|mem_wstrb_i) ? 3'd1 : 3'd4;
          tx_bit <= 4'd9;
          tx_cnt <= '0;
        end
        TX: if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
        else if (tx_bit != 4'd9) begin
          tx_o <= tx_sh[0];
          tx_sh <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 1'b1;
          tx_cnt <= CW'(BitCycles - 1);
        end else if (tx_left != 4'd0) begin
          tx_o <= 1'b0;
          tx_sh <= {1'b1, frm[7:0]};
          frm <= {8'h0, frm[79:8]};
          tx_left <= tx_left - 1'b1;
          tx_bit <= 4'd0;
          tx_cnt <= CW'(BitCycles - 1);
        end else begin
          state <= RX_RESP;
          tmo <= '0;
        end
        RX_RESP: if (rx_vld) begin
          tmo <= '0;
          rsh <= {rx_sh, rsh[31:8]};
          rx_num <= rx_num - 1'b1;
          if (rx_num == 3'd1) begin
            state <= DONE;
            mem_ready_o <= 1'b1;
            if (!wr) mem_rdata_o <= {rx_sh, rsh[31:8]};
            else if (rx_sh != 8'h06) err_o <= 1'b1;
          end
        end else if (tmo == TW'(TimeoutCycles - 1)) begin
          state <= DONE;
          mem_ready_o <= 1'b1;
          err_o <= 1'b1;
          if (!wr) mem_rdata_o <= '1;
        end else tmo <= tmo + 1'b1;
        default: begin
          state <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
endmodule
